// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver: shared segment bus, per-slot ghost blanking,
// frame-coherent shadow registers, leading-zero suppression and per-digit dp/blank.
module seven_seg_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int HEX_MODE     = 0,
  parameter int AN_ACT_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  input  logic                  lzs_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF =
    (AN_ACT_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  // Scan position
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Frame shadow registers
  logic [4*N_DIGITS-1:0] digits_q;
  logic [N_DIGITS-1:0]   dp_sh_q;
  logic [N_DIGITS-1:0]   blank_q;
  logic                  lzs_q;

  // Registered outputs
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_q, frame_d;

  logic                  snap;
  logic [4*N_DIGITS-1:0] cur_digits;
  logic [N_DIGITS-1:0]   cur_dp;
  logic [N_DIGITS-1:0]   cur_blank;
  logic                  cur_lzs;

  logic [3:0]          digit_val [N_DIGITS];
  logic [6:0]          slot_seg  [N_DIGITS];
  logic [N_DIGITS-1:0] zero_vec;
  logic [N_DIGITS-1:0] suppress;
  logic [N_DIGITS-1:0] slot_dp;
  logic [N_DIGITS-1:0] an_onehot;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic hex;
    hex = (HEX_MODE != 0);
    case (v)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = hex ? 7'h77 : 7'h00;
      4'hB: decode = hex ? 7'h7C : 7'h00;
      4'hC: decode = hex ? 7'h39 : 7'h00;
      4'hD: decode = hex ? 7'h5E : 7'h00;
      4'hE: decode = hex ? 7'h79 : 7'h00;
      default: decode = hex ? 7'h71 : 7'h00;
    endcase
  endfunction

  // The snapshot cycle decodes straight from the inputs so the first slot of a frame
  // already sees the data being captured, even when BLANK_CYCLES is 0.
  assign snap       = enable_i && (slot_cnt_q == '0) && (idx_q == '0);
  assign cur_digits = snap ? digits_i : digits_q;
  assign cur_dp     = snap ? dp_i     : dp_sh_q;
  assign cur_blank  = snap ? blank_i  : blank_q;
  assign cur_lzs    = snap ? lzs_i    : lzs_q;

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign digit_val[gi] = cur_digits[4*gi +: 4];
      assign zero_vec[gi]  = (digit_val[gi] == 4'd0);
      // A digit is a leading zero when it and every more significant digit are zero.
      if (gi == 0) begin : g_lsd
        assign suppress[gi] = 1'b0;
      end else begin : g_upper
        assign suppress[gi] = cur_lzs && (&zero_vec[N_DIGITS-1:gi]);
      end
      assign slot_seg[gi]  = (cur_blank[gi] || suppress[gi]) ? 7'h00 : decode(digit_val[gi]);
      assign slot_dp[gi]   = cur_dp[gi] && !cur_blank[gi];
      assign an_onehot[gi] = (idx_q == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    slot_cnt_d = slot_cnt_q;
    idx_d      = idx_q;
    if (!enable_i) begin
      slot_cnt_d = '0;
      idx_d      = '0;
    end else if (slot_cnt_q == CNT_MAX) begin
      slot_cnt_d = '0;
      idx_d      = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else begin
      slot_cnt_d = slot_cnt_q + 1'b1;
    end
  end

  always_comb begin
    seg_d   = 7'h00;
    dp_d    = 1'b0;
    an_d    = AN_OFF;
    frame_d = snap;
    if (enable_i && (slot_cnt_q >= BLANK_END)) begin
      an_d  = AN_OFF ^ an_onehot;
      seg_d = slot_seg[idx_q];
      dp_d  = slot_dp[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
      digits_q   <= '0;
      dp_sh_q    <= '0;
      blank_q    <= '0;
      lzs_q      <= 1'b0;
      seg_q      <= 7'h00;
      dp_q       <= 1'b0;
      an_q       <= AN_OFF;
      frame_q    <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      if (snap) begin
        digits_q <= digits_i;
        dp_sh_q  <= dp_i;
        blank_q  <= blank_i;
        lzs_q    <= lzs_i;
      end
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomised and directed bench for seven_seg_scan_driver; a decimal and a hex build share
// stimulus and are checked against a frame-position reference model.
module tb_seven_seg_scan_driver;
  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;

  localparam logic [6:0] DEC_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  localparam logic [6:0] HEX_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic [6:0]   seg_hex;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic [4*N-1:0] digits = '0;
  logic [N-1:0] dp = '0, blank = '0;
  logic lzs = 1'b0;

  logic [6:0] seg_o, seg_hex;
  logic dp_o, dp_hex, frame_o, frame_hex;
  logic [N-1:0] an_o, an_hex;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK),
                          .HEX_MODE(0), .AN_ACT_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .digits_i(digits), .dp_i(dp),
    .blank_i(blank), .lzs_i(lzs), .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o));

  seven_seg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK),
                          .HEX_MODE(1), .AN_ACT_LOW(1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .digits_i(digits), .dp_i(dp),
    .blank_i(blank), .lzs_i(lzs), .seg_o(seg_hex), .dp_o(dp_hex), .an_o(an_hex),
    .frame_o(frame_hex));

  // Expected display for frame position p (0..N*DIV-1) given the frame's captured inputs.
  function automatic exp_t model_out(int p, logic [4*N-1:0] dg, logic [N-1:0] dpv,
                                     logic [N-1:0] blv, logic lz);
    exp_t e;
    int k, sub;
    logic [3:0] v;
    bit sup;
    e = '{seg: 7'h00, dp: 1'b0, an: {N{1'b1}}, seg_hex: 7'h00};
    k = p / DIV;
    sub = p % DIV;
    if (sub >= BLANK) begin
      e.an = ~(N'(1) << k);
      v = dg[4*k +: 4];
      sup = lz && (k != 0);
      for (int j = k; j < N; j++) if (dg[4*j +: 4] != 4'd0) sup = 1'b0;
      if (!blv[k]) begin
        e.dp = dpv[k];
        if (!sup) begin
          e.seg = DEC_TAB[v];
          e.seg_hex = HEX_TAB[v];
        end
      end
    end
    return e;
  endfunction

  int pos;
  logic [4*N-1:0] sh_dg;
  logic [N-1:0] sh_dp, sh_bl;
  logic sh_lz;
  exp_t exp_q;
  logic exp_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= 0;
      sh_dg <= '0; sh_dp <= '0; sh_bl <= '0; sh_lz <= 1'b0;
      exp_q <= '{seg: 7'h00, dp: 1'b0, an: {N{1'b1}}, seg_hex: 7'h00};
      exp_frame <= 1'b0;
    end else if (!enable) begin
      pos <= 0;
      exp_q <= '{seg: 7'h00, dp: 1'b0, an: {N{1'b1}}, seg_hex: 7'h00};
      exp_frame <= 1'b0;
    end else if (pos == 0) begin
      sh_dg <= digits; sh_dp <= dp; sh_bl <= blank; sh_lz <= lzs;
      exp_q <= model_out(0, digits, dp, blank, lzs);
      exp_frame <= 1'b1;
      pos <= 1;
    end else begin
      exp_q <= model_out(pos, sh_dg, sh_dp, sh_bl, sh_lz);
      exp_frame <= 1'b0;
      pos <= (pos + 1) % (N * DIV);
    end
  end

  logic [25:0] obs_vec, exp_vec;
  localparam logic [25:0] DARK_VEC = {7'h00, 1'b0, 4'hF, 1'b0, 7'h00, 1'b0, 4'hF, 1'b0};
  assign obs_vec = {seg_o, dp_o, an_o, frame_o, seg_hex, dp_hex, an_hex, frame_hex};
  assign exp_vec = {exp_q.seg, exp_q.dp, exp_q.an, exp_frame,
                    exp_q.seg_hex, exp_q.dp, exp_q.an, exp_frame};

  // Advances to the negedge right after a frame_o pulse, giving up after a cycle budget.
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (frame_o === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; digits = '0; dp = '0; blank = '0; lzs = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_vec !== DARK_VEC) begin
      n_err++; $display("FAIL reset_state got %h expected %h", obs_vec, DARK_VEC);
    end
  endtask

  task automatic test_scan;
    digits = 16'h1234;
    rst_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++; $display("FAIL scan c=%0d got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 1 || c == 33) begin
        n_cmp++;
        if (frame_o !== 1'b1) begin n_err++; $display("FAIL scan_frame c=%0d got %b expected 1", c, frame_o); end
      end
      if (c == 3) begin
        n_cmp++;
        if ({an_o, seg_o} !== {4'b1110, 7'h66}) begin
          n_err++; $display("FAIL scan_idx0 got an=%b seg=%h expected an=1110 seg=66", an_o, seg_o);
        end
      end
      if (c == 11) begin
        n_cmp++;
        if ({an_o, seg_o} !== {4'b1101, 7'h4F}) begin
          n_err++; $display("FAIL scan_idx1 got an=%b seg=%h expected an=1101 seg=4f", an_o, seg_o);
        end
      end
    end
  endtask

  task automatic test_no_tearing;
    bit ok;
    wait_frame(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL tear_wait got no frame_o expected pulse"); end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 11) digits = 16'h5678;
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++; $display("FAIL tear c=%0d got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 26) begin
        n_cmp++;
        if (seg_o !== 7'h06) begin n_err++; $display("FAIL tear_old got seg=%h expected 06", seg_o); end
      end
      if (c == 34) begin
        n_cmp++;
        if (seg_o !== 7'h7F) begin n_err++; $display("FAIL tear_new got seg=%h expected 7f", seg_o); end
      end
    end
  endtask

  task automatic test_lzs;
    bit ok;
    lzs = 1'b1; digits = 16'h0007; dp = 4'b0100;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin digits = 16'h0000; dp = 4'b0000; end
      wait_frame(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL lzs_wait got no frame_o expected pulse"); end
      for (int c = 1; c <= 32; c++) begin
        @(negedge clk);
        n_cmp++;
        if (obs_vec !== exp_vec) begin
          n_err++; $display("FAIL lzs p%0d c=%0d got %h expected %h", pass, c, obs_vec, exp_vec);
        end
        if (c == 2) begin
          n_cmp++;
          if (seg_o !== (pass == 0 ? 7'h07 : 7'h3F)) begin
            n_err++; $display("FAIL lzs_d0 p%0d got seg=%h expected %h", pass, seg_o,
                              (pass == 0 ? 7'h07 : 7'h3F));
          end
        end
        if (c == 18 && pass == 0) begin
          n_cmp++;
          if ({an_o, seg_o, dp_o} !== {4'b1011, 7'h00, 1'b1}) begin
            n_err++; $display("FAIL lzs_d2 got an=%b seg=%h dp=%b expected an=1011 seg=00 dp=1",
                              an_o, seg_o, dp_o);
          end
        end
        if (c == 10) begin
          n_cmp++;
          if ({seg_o, dp_o} !== 8'h00) begin
            n_err++; $display("FAIL lzs_d1 p%0d got seg=%h dp=%b expected seg=00 dp=0", pass, seg_o, dp_o);
          end
        end
      end
    end
    lzs = 1'b0;
  endtask

  task automatic test_hex;
    bit ok;
    digits = 16'hABCD;
    wait_frame(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL hex_wait got no frame_o expected pulse"); end
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++; $display("FAIL hex c=%0d got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 2 || c == 26) begin
        n_cmp++;
        if ({seg_hex, seg_o} !== {(c == 2 ? 7'h5E : 7'h77), 7'h00}) begin
          n_err++; $display("FAIL hex_dec c=%0d got hex=%h dec=%h expected hex=%h dec=00", c, seg_hex,
                            seg_o, (c == 2 ? 7'h5E : 7'h77));
        end
      end
    end
  endtask

  task automatic test_blank;
    bit ok;
    for (int k = 0; k < N; k++) digits[4*k +: 4] = 4'($urandom_range(0, 9));
    dp = 4'($urandom_range(0, 15));
    blank = 4'b0010;
    wait_frame(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL blank_wait got no frame_o expected pulse"); end
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++; $display("FAIL blank c=%0d got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 10) begin
        n_cmp++;
        if ({an_o, seg_o, dp_o} !== {4'b1101, 7'h00, 1'b0}) begin
          n_err++; $display("FAIL blank_d1 got an=%b seg=%h dp=%b expected an=1101 seg=00 dp=0",
                            an_o, seg_o, dp_o);
        end
      end
    end
    blank = '0;
  endtask

  task automatic test_enable_drop;
    bit ok;
    digits = 16'h1234;
    wait_frame(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL en_wait got no frame_o expected pulse"); end
    repeat (19) @(negedge clk);
    enable = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 4) enable = 1'b1;
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++; $display("FAIL en c=%0d got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 1) begin
        n_cmp++;
        if ({an_o, seg_o} !== {4'hF, 7'h00}) begin
          n_err++; $display("FAIL en_dark got an=%b seg=%h expected an=1111 seg=00", an_o, seg_o);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (frame_o !== 1'b1) begin n_err++; $display("FAIL en_restart got frame=%b expected 1", frame_o); end
      end
      if (c == 7) begin
        n_cmp++;
        if ({an_o, seg_o} !== {4'b1110, 7'h66}) begin
          n_err++; $display("FAIL en_idx0 got an=%b seg=%h expected an=1110 seg=66", an_o, seg_o);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    wait_frame(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL arst_wait got no frame_o expected pulse"); end
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec !== DARK_VEC) begin
      n_err++; $display("FAIL arst_dark got %h expected %h", obs_vec, DARK_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++; $display("FAIL arst c=%0d got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 1) begin
        n_cmp++;
        if (frame_o !== 1'b1) begin n_err++; $display("FAIL arst_frame got frame=%b expected 1", frame_o); end
      end
    end
  endtask

  task automatic test_random;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_err++; $display("FAIL rand c=%0d got %h expected %h", c, obs_vec, exp_vec);
      end
      if ($urandom_range(0, 7) == 0) begin
        digits = 16'($urandom);
        if ($urandom_range(0, 1) == 0) digits = digits & 16'h00FF;
        dp = 4'($urandom);
        blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        lzs = 1'($urandom);
      end
      if ($urandom_range(0, 59) == 0) enable = ~enable;
    end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_no_tearing();
    test_lzs();
    test_hex();
    test_blank();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
